parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares one barrier gate between the entrance lane (password-checked) and the exit lane.
//  Sequences the gate motor (open -> car passes -> close) and tracks lot occupancy against capacity.
//  Sits between the per-lane parking_system FSMs and the gate motor driver.
// PARAMETERS
//  CAPACITY      8   number of bays; entry is refused when occupancy == CAPACITY
//  PASS_TIMEOUT  64  cycles allowed per service phase (OPENING, PASSING) before abort
//  (localparams) CNT_W = $clog2(CAPACITY+1), TMR_W = $clog2(PASS_TIMEOUT)
// PORTS
//  clk             in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-low reset
//  entry_req       in   1      level; entrance car waiting
//  entry_pass_ok   in   1      level; entrance password verified
//  exit_req        in   1      level; exit car waiting
//  gate_open_done  in   1      level; barrier fully open
//  gate_closed     in   1      level; barrier fully closed
//  car_through     in   1      1-cycle pulse; car cleared the gate
//  gate_open_cmd   out  1      drive barrier open (held in OPENING)
//  gate_close_cmd  out  1      drive barrier closed (held in CLOSING)
//  entry_grant     out  1      entrance owns the gate (OPENING..CLOSING)
//  exit_grant      out  1      exit owns the gate (OPENING..CLOSING)
//  occupancy       out  CNT_W  cars currently parked
//  lot_full        out  1      occupancy == CAPACITY
//  lot_empty       out  1      occupancy == 0
//  timeout_err     out  1      1-cycle pulse on phase timeout
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, occupancy=0, timer=0, last_served=EXIT; all outputs 0 except lot_empty=1.
//  All outputs are registered. lot_full/lot_empty are decoded from the occupancy register.
//  Eligibility: ent_ok = entry_req & entry_pass_ok & ~lot_full; ext_ok = exit_req & ~lot_empty.
//  IDLE:    if ent_ok|ext_ok, pick owner -> OPENING. Grant and gate_open_cmd go high 1 cycle after the eligible edge.
//           Both eligible: round-robin; owner = requester != last_served (first contest after reset -> entry).
//  OPENING: gate_open_cmd=1. gate_open_done -> PASSING, timer cleared. Timer hits PASS_TIMEOUT-1 -> CLOSING + timeout_err.
//  PASSING: car_through -> occupancy +1 (entry) / -1 (exit), last_served=owner, go to CLOSING.
//           Timer hits PASS_TIMEOUT-1 with no car_through -> CLOSING + timeout_err; occupancy and last_served unchanged.
//           car_through and timer expiry in the same cycle: car_through wins, no timeout_err.
//  CLOSING: gate_close_cmd=1. No timeout. gate_closed -> IDLE; grant drops on the same edge.
//  Once granted, a session is committed: dropping req/pass_ok mid-session does not abort it.
//  car_through outside PASSING is ignored.
//  Occupancy saturates at 0 and CAPACITY; eligibility prevents over/underflow, and a saturating guard is kept anyway.
//  entry_grant and exit_grant are never high together; gate_open_cmd and gate_close_cmd are never high together.
//  Reset asserted mid-session: immediate return to reset values, including occupancy=0.
// CONFIGURATION
//  PARK_ARB_EXIT_PRIO_EN defined: when both lanes are eligible, exit always wins (frees bays first);
//    last_served is still updated but not used for selection.
//  Not defined: round-robin as described above.
// STRUCTURE
//  parking_pkg: state encodings (IDLE=3'b000, OPENING=3'b001, PASSING=3'b010, CLOSING=3'b011),
//    owner encoding (OWN_ENTRY=1'b0, OWN_EXIT=1'b1).
//  Sub-module parking_phase_timer: clear/enable inputs, expire output at PASS_TIMEOUT-1; used for OPENING and PASSING.
// TESTING
//  1 Entry path: occ=0, entry_req=1, pass_ok=1 -> entry_grant and open_cmd the next cycle;
//    open_done, then car_through -> occ=1; gate_closed -> IDLE, grant=0.
//  2 Full lot: fill to 8 -> lot_full=1; further entry_req+pass_ok -> no grant; exit_req -> exit_grant, occ=7 after car_through.
//  3 Contest: occ=3, both eligible every cycle -> grants alternate entry, exit, entry...;
//    with PARK_ARB_EXIT_PRIO_EN -> exit, exit, exit...
//  4 Timeout: grant, open_done, no car_through for 64 cycles -> timeout_err 1-cycle pulse,
//    close_cmd=1, occ unchanged, next contest winner unchanged.
//  5 Corner: car_through on the expiry cycle -> occ updated, no timeout_err; exit_req at occ=0 -> never granted.
//  6 Reset in PASSING at occ=5 -> all outputs 0, occ=0, lot_empty=1 asynchronously; normal entry works after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared encodings for the parking gate arbiter: FSM states and gate owner.
// No logic, no latency.
// No flow control here; consumers apply their own.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        OPENING = 3'b001,
        PASSING = 3'b010,
        CLOSING = 3'b011
    } arb_state_t;

    typedef enum logic {
        OWN_ENTRY = 1'b0,
        OWN_EXIT  = 1'b1
    } owner_t;

endpackage

// File: rtl/parking_phase_timer.sv
// Per-phase cycle counter; expire flags the last allowed cycle of a service phase.
// expire is decoded from the count register, so it is valid the cycle the count reaches PASS_TIMEOUT-1.
// No backpressure; clear has priority over enable.
module parking_phase_timer #(
    parameter int PASS_TIMEOUT = 64,
    parameter int TMR_W        = $clog2(PASS_TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] count;

    // Count cycles spent in the current phase; restart whenever the phase is (re)entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TMR_W'(PASS_TIMEOUT - 1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entrance and exit lanes, sequences the motor, tracks occupancy.
// Grant/open_cmd register 1 cycle after a lane becomes eligible; all outputs are register-driven.
// Lanes wait on their level requests; sessions commit once granted. Macro PARK_ARB_EXIT_PRIO_EN: exit wins contests.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter  int CAPACITY     = 8,
    parameter  int PASS_TIMEOUT = 64,
    localparam int CNT_W        = $clog2(CAPACITY + 1),
    localparam int TMR_W        = $clog2(PASS_TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_pass_ok,
    input  logic             exit_req,
    input  logic             gate_open_done,
    input  logic             gate_closed,
    input  logic             car_through,
    output logic             gate_open_cmd,
    output logic             gate_close_cmd,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             timeout_err
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_served;
    owner_t     pick;
    logic       ent_ok;
    logic       ext_ok;
    logic       tmr_clear;
    logic       tmr_expire;

    assign lot_full  = (occupancy == CNT_W'(CAPACITY));
    assign lot_empty = (occupancy == '0);

    // Eligibility and owner selection for the next session.
    always_comb begin
        ent_ok = entry_req & entry_pass_ok & ~lot_full;
        ext_ok = exit_req & ~lot_empty;
        pick   = OWN_ENTRY;
`ifdef PARK_ARB_EXIT_PRIO_EN
        // Exit always wins a contest so bays are freed first.
        if (ext_ok) pick = OWN_EXIT;
`else
        // Contest goes to the lane that was not served last.
        if (ext_ok && (!ent_ok || last_served == OWN_ENTRY)) pick = OWN_EXIT;
`endif
    end

    // Timer runs only inside OPENING/PASSING and restarts on the OPENING->PASSING step.
    assign tmr_clear = !((state == OPENING) || (state == PASSING)) ||
                       ((state == OPENING) && gate_open_done);

    parking_phase_timer #(
        .PASS_TIMEOUT (PASS_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (!tmr_clear),
        .expire (tmr_expire)
    );

    // Gate session FSM with registered motor commands, grants, occupancy and timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= OWN_ENTRY;
            last_served    <= OWN_EXIT;
            occupancy      <= '0;
            gate_open_cmd  <= 1'b0;
            gate_close_cmd <= 1'b0;
            entry_grant    <= 1'b0;
            exit_grant     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ent_ok || ext_ok) begin
                        state         <= OPENING;
                        owner         <= pick;
                        gate_open_cmd <= 1'b1;
                        entry_grant   <= (pick == OWN_ENTRY);
                        exit_grant    <= (pick == OWN_EXIT);
                    end
                end
                OPENING: begin
                    if (gate_open_done) begin
                        state         <= PASSING;
                        gate_open_cmd <= 1'b0;
                    end else if (tmr_expire) begin
                        state          <= CLOSING;
                        gate_open_cmd  <= 1'b0;
                        gate_close_cmd <= 1'b1;
                        timeout_err    <= 1'b1;
                    end
                end
                PASSING: begin
                    // A car clearing on the expiry cycle still counts.
                    if (car_through) begin
                        if (owner == OWN_ENTRY) begin
                            if (!lot_full) occupancy <= occupancy + 1'b1;
                        end else begin
                            if (!lot_empty) occupancy <= occupancy - 1'b1;
                        end
                        last_served    <= owner;
                        state          <= CLOSING;
                        gate_close_cmd <= 1'b1;
                    end else if (tmr_expire) begin
                        state          <= CLOSING;
                        gate_close_cmd <= 1'b1;
                        timeout_err    <= 1'b1;
                    end
                end
                CLOSING: begin
                    if (gate_closed) begin
                        state          <= IDLE;
                        gate_close_cmd <= 1'b0;
                        entry_grant    <= 1'b0;
                        exit_grant     <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    gate_open_cmd  <= 1'b0;
                    gate_close_cmd <= 1'b0;
                    entry_grant    <= 1'b0;
                    exit_grant     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus randomized lane/gate traffic.
// A session-level model predicts every output each cycle; literal checks pin the scenarios.
// Honours PARK_ARB_EXIT_PRIO_EN for contest expectations.
module tb_parking_gate_arbiter;

    localparam int CAP = 8;
    localparam int TMO = 64;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       entry_req = 1'b0;
    logic       entry_pass_ok = 1'b0;
    logic       exit_req = 1'b0;
    logic       gate_open_done = 1'b0;
    logic       gate_closed = 1'b0;
    logic       car_through = 1'b0;
    logic       gate_open_cmd;
    logic       gate_close_cmd;
    logic       entry_grant;
    logic       exit_grant;
    logic [3:0] occupancy;
    logic       lot_full;
    logic       lot_empty;
    logic       timeout_err;

    always #5 clk = ~clk;

    parking_gate_arbiter #(
        .CAPACITY     (CAP),
        .PASS_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry_req      (entry_req),
        .entry_pass_ok  (entry_pass_ok),
        .exit_req       (exit_req),
        .gate_open_done (gate_open_done),
        .gate_closed    (gate_closed),
        .car_through    (car_through),
        .gate_open_cmd  (gate_open_cmd),
        .gate_close_cmd (gate_close_cmd),
        .entry_grant    (entry_grant),
        .exit_grant     (exit_grant),
        .occupancy      (occupancy),
        .lot_full       (lot_full),
        .lot_empty      (lot_empty),
        .timeout_err    (timeout_err)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Session-level model: which phase the gate is in, who holds it, how long the phase has lasted.
    localparam int PH_IDLE  = 0;
    localparam int PH_OPEN  = 1;
    localparam int PH_PASS  = 2;
    localparam int PH_CLOSE = 3;

    int m_phase = PH_IDLE;
    int m_occ = 0;
    int m_age = 0;
    bit m_own_exit = 0;
    bit m_last_exit = 1;
    bit m_terr = 0;

    always @(posedge clk or negedge reset) begin : model
        bit ent;
        bit ext;
        if (!reset) begin
            m_phase = PH_IDLE; m_occ = 0; m_age = 0;
            m_own_exit = 0; m_last_exit = 1; m_terr = 0;
        end else begin
            m_terr = 0;
            case (m_phase)
                PH_IDLE: begin
                    ent = entry_req && entry_pass_ok && (m_occ < CAP);
                    ext = exit_req && (m_occ > 0);
                    if (ent || ext) begin
`ifdef PARK_ARB_EXIT_PRIO_EN
                        m_own_exit = ext;
`else
                        m_own_exit = (ent && ext) ? !m_last_exit : ext;
`endif
                        m_phase = PH_OPEN;
                        m_age = 0;
                    end
                end
                PH_OPEN: begin
                    if (gate_open_done) begin
                        m_phase = PH_PASS; m_age = 0;
                    end else if (m_age == TMO - 1) begin
                        m_phase = PH_CLOSE; m_terr = 1;
                    end else m_age++;
                end
                PH_PASS: begin
                    if (car_through) begin
                        m_occ = m_own_exit ? ((m_occ > 0) ? m_occ - 1 : 0)
                                           : ((m_occ < CAP) ? m_occ + 1 : CAP);
                        m_last_exit = m_own_exit;
                        m_phase = PH_CLOSE;
                    end else if (m_age == TMO - 1) begin
                        m_phase = PH_CLOSE; m_terr = 1;
                    end else m_age++;
                end
                default: begin
                    if (gate_closed) m_phase = PH_IDLE;
                end
            endcase
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("entry_grant", entry_grant, (m_phase != PH_IDLE) && !m_own_exit);
            check("exit_grant", exit_grant, (m_phase != PH_IDLE) && m_own_exit);
            check("gate_open_cmd", gate_open_cmd, m_phase == PH_OPEN);
            check("gate_close_cmd", gate_close_cmd, m_phase == PH_CLOSE);
            check("occupancy", occupancy, m_occ);
            check("lot_full", lot_full, m_occ == CAP);
            check("lot_empty", lot_empty, m_occ == 0);
            check("timeout_err", timeout_err, m_terr);
        end
    end

    task automatic session(input bit want_ent, input bit want_ext, output int who);
        entry_req = want_ent; entry_pass_ok = want_ent; exit_req = want_ext;
        @(negedge clk);
        who = entry_grant ? 1 : (exit_grant ? 2 : 0);
        entry_req = 0; entry_pass_ok = 0; exit_req = 0;
        if (who != 0) begin
            check("sess_open_cmd", gate_open_cmd, 1);
            gate_open_done = 1; @(negedge clk); gate_open_done = 0;
            car_through = 1; @(negedge clk); car_through = 0;
            gate_closed = 1; @(negedge clk); gate_closed = 0;
        end
    endtask

    initial begin
        int who;
        int n;
        int exp_contest [2];
        int exp_after_to;
        int occ3;
`ifdef PARK_ARB_EXIT_PRIO_EN
        exp_contest = '{2, 2}; occ3 = 1; exp_after_to = 2;
`else
        exp_contest = '{1, 2}; occ3 = 3; exp_after_to = 1;
`endif
        #1 reset = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        check("rst_occ", occupancy, 0);
        check("rst_empty", lot_empty, 1);
        check("rst_full", lot_full, 0);
        check("rst_grants", {entry_grant, exit_grant, gate_open_cmd, gate_close_cmd, timeout_err}, 0);
        reset = 1;
        @(negedge clk);

        // Entry path
        session(1, 0, who);
        check("t1_who", who, 1);
        check("t1_occ", occupancy, 1);
        check("t1_grant_drop", entry_grant, 0);

        // Full lot
        repeat (7) session(1, 0, who);
        check("t2_occ8", occupancy, 8);
        check("t2_full", lot_full, 1);
        entry_req = 1; entry_pass_ok = 1;
        repeat (4) @(negedge clk);
        check("t2_no_grant", entry_grant, 0);
        check("t2_no_open", gate_open_cmd, 0);
        entry_req = 0; entry_pass_ok = 0;
        session(0, 1, who);
        check("t2_exit_who", who, 2);
        check("t2_occ7", occupancy, 7);

        // Contest
        repeat (4) session(0, 1, who);
        check("t3_occ3", occupancy, 3);
        for (int i = 0; i < 2; i++) begin
            session(1, 1, who);
            check("t3_contest", who, exp_contest[i]);
        end
        check("t3_occ", occupancy, occ3);

        // Timeout in PASSING
        entry_req = 1; entry_pass_ok = 1;
        @(negedge clk);
        check("t4_grant", entry_grant, 1);
        entry_req = 0; entry_pass_ok = 0;
        gate_open_done = 1; @(negedge clk); gate_open_done = 0;
        for (n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (timeout_err) break;
        end
        check("t4_latency", n, TMO);
        check("t4_close_cmd", gate_close_cmd, 1);
        check("t4_occ", occupancy, occ3);
        @(negedge clk);
        check("t4_pulse", timeout_err, 0);
        gate_closed = 1; @(negedge clk); gate_closed = 0;
        session(1, 1, who);
        check("t4_next_winner", who, exp_after_to);

        // car_through on the expiry cycle
        while (m_occ < 4) session(1, 0, who);
        entry_req = 1; entry_pass_ok = 1;
        @(negedge clk);
        entry_req = 0; entry_pass_ok = 0;
        gate_open_done = 1; @(negedge clk); gate_open_done = 0;
        repeat (TMO - 1) @(negedge clk);
        car_through = 1; @(negedge clk); car_through = 0;
        check("t5_no_terr", timeout_err, 0);
        check("t5_occ5", occupancy, 5);
        check("t5_close", gate_close_cmd, 1);
        gate_closed = 1; @(negedge clk); gate_closed = 0;

        // Reset in PASSING at occupancy 5
        entry_req = 1; entry_pass_ok = 1;
        @(negedge clk);
        entry_req = 0; entry_pass_ok = 0;
        gate_open_done = 1; @(negedge clk); gate_open_done = 0;
        #3 reset = 0;
        #1;
        check("t6_occ", occupancy, 0);
        check("t6_empty", lot_empty, 1);
        check("t6_outs", {entry_grant, exit_grant, gate_open_cmd, gate_close_cmd, timeout_err, lot_full}, 0);
        @(negedge clk);
        reset = 1;
        exit_req = 1;
        repeat (10) @(negedge clk);
        check("t5_exit_empty", exit_grant, 0);
        exit_req = 0;
        session(1, 0, who);
        check("t6_after_who", who, 1);
        check("t6_after_occ", occupancy, 1);

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            entry_req      = ($urandom_range(0, 2) != 0);
            entry_pass_ok  = ($urandom_range(0, 2) != 0);
            exit_req       = ($urandom_range(0, 1) != 0);
            gate_open_done = ($urandom_range(0, 3) == 0);
            gate_closed    = ($urandom_range(0, 3) == 0);
            car_through    = ($urandom_range(0, 5) == 0);
        end
        entry_req = 0; entry_pass_ok = 0; exit_req = 0;
        gate_open_done = 0; gate_closed = 0; car_through = 0;
        @(negedge clk);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
